mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS-subset datapath. The control unit drives it with one-cycle `MULT_on` / `DIV_on` start strobes, holding operands on A/B. The unit runs a 32-iteration shift-add multiply or a restoring divide, writes a 64-bit result into internal Hi/Lo registers and pulses `done`. A zero divisor raises `div_zero`, which the control unit turns into the divide-by-zero exception.

## Interface
Parameters:
- `WIDTH`, 32: operand width; Hi/Lo are each `WIDTH` bits.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  reset; one clock; reset is synchronous and active-low.
- `mult_start`  in  1  one-cycle strobe from `MULT_on`; start signed multiply.
- `div_start`  in  1  one-cycle strobe from `DIV_on`; start signed divide.
- `a`  in  WIDTH  operand A (multiplicand / dividend), sampled on the start cycle only.
- `b`  in  WIDTH  operand B (multiplier / divisor), sampled on the start cycle only.
- `hi`  out  WIDTH  product[63:32] or remainder.
- `lo`  out  WIDTH  product[31:0] or quotient.
- `busy`  out  1  high from the cycle after an accepted start until `done` inclusive.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid and updated in that cycle.
- `div_zero`  out  1  one-cycle pulse; divide was started with `b == 0`.

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE.
- **IDLE**
  - `mult_start`: latch `a`, `b`; go to MULT_RUN with iteration counter = 0.
  - `div_start` with `b != 0`: latch |a|, |b| and both signs; go to DIV_RUN.
  - `div_start` with `b == 0`: stay in IDLE and pulse `div_zero` next cycle. `hi`/`lo` are unchanged and there is no `done`.
  - Both starts high together: the multiply wins and `div_start` is dropped.
- **MULT_RUN**
  - One radix-2 Booth step per cycle on a 64-bit accumulator plus one guard bit.
  - Exactly 32 cycles, then DONE.
  - Full signed 64-bit product; no overflow is possible.
- **DIV_RUN**
  - One restoring step per cycle on magnitudes; 32 cycles, then DIV_FIX.
- **DIV_FIX**
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Quotient truncates toward zero.
  - Then DONE.
- **DONE**
  - Register the result into `hi`/`lo`, pulse `done`, return to IDLE.
- Start strobes are ignored outside IDLE.
- Operand changes during a run are ignored.
- `hi`/`lo` hold their value until the next `done` (mfhi/mflo read them any time).
- -2^31 / -1: quotient 0x80000000 (wraps), remainder 0. No flag is raised.

## Timing
- Start sampled at edge N:
  - multiply: `busy` high N+1..N+33, `done` at N+33;
  - divide: `busy` high N+1..N+34, `done` at N+34;
  - zero divisor: `div_zero` at N+1, `busy` stays low.
- A new start is accepted in the cycle after `done` (back in IDLE).
- Reset values when `reset` is sampled low:
  - state IDLE, counter 0;
  - `hi` = `lo` = 0;
  - `busy` = `done` = `div_zero` = 0.
- Reset mid-operation aborts the run with no `done`; reset overrides a coincident start.

## Configuration
- `MULTDIV_DIV_EN`:
  - defined: the divider (DIV_RUN, DIV_FIX, `div_zero`) is compiled in;
  - undefined: `div_start` is ignored, `div_zero` is tied 0 and only the multiply path exists.
- The multiply behaviour is identical either way.

## Structure
- Shared package `multdiv_pkg`:
  - state enum;
  - `MD_ITER = 32`;
  - `MD_MULT_LAT = 33`, `MD_DIV_LAT = 34` (used by the control unit's wait states and the bench).
- One sub-module: `div_core`. It does one restoring-divide step (remainder/quotient shift, trial subtract, restore) and is instantiated combinationally inside the iteration loop.
- Booth step and sign fix-up stay in the top module.

## Test plan
- Multiply 7 × -3 -> `done` at N+33, `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- Multiply 0x7FFFFFFF × 0x7FFFFFFF -> `hi` = 0x3FFFFFFF, `lo` = 0x00000001.
- Divide -7 / 2 -> `done` at N+34, `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Then divide 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0.
- Divide 5 / 0 after a prior result -> `div_zero` pulse at N+1, no `done`, `busy` low, `hi`/`lo` keep the prior values.
- Both starts together with a = 6, b = 4 -> multiply only: `hi` = 0, `lo` = 24. A `div_start` during the run is ignored.
- `reset` low at N+10 of a multiply -> IDLE with all outputs 0, no `done`. A start right after reset completes normally.

Source files
------------

// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared types and latency constants for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MULT_RUN = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } md_state_e;

    localparam int MD_ITER     = 32;
    localparam int MD_MULT_LAT = 33;
    localparam int MD_DIV_LAT  = 34;

endpackage

`default_nettype wire

// File: rtl/div_core.sv
// ============================================================================
// Module      : div_core
// Description : One combinational restoring-divide step on unsigned magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Remainder stays below the divisor, so one extra bit is enough to see the borrow.
    always_comb begin
        w_shifted = {i_rem, i_quo[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, i_divisor};
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shifted[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed Booth multiply / restoring divide into Hi/Lo.
//               Divider compiled in only when MULTDIV_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int              c_CW        = $clog2(MD_ITER);
    localparam logic [c_CW-1:0] c_LAST_ITER = c_CW'(MD_ITER - 1);

    md_state_e        r_state, w_state_next;
    logic [c_CW-1:0]  r_cnt;
    // Upper half carries one sign-extension bit so A = -2^WIDTH-1 cannot overflow.
    logic [WIDTH:0]   r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic             r_guard;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic             w_last;
    logic             w_div_accept;
    logic [WIDTH:0]   w_mcand_ext, w_booth_sum, w_booth_hi;
    logic [WIDTH-1:0] w_booth_lo;
    logic             w_booth_guard;

`ifdef MULTDIV_DIV_EN
    // Divide reuses the accumulator: r_acc_hi = remainder, r_acc_lo = quotient, r_mcand = divisor.
    logic             w_div_req, w_div_zero_req;
    logic             r_div_zero, r_sign_a, r_sign_b;
    logic [WIDTH-1:0] w_rem_next, w_quo_next;

    assign w_div_req      = div_start & ~mult_start;
    assign w_div_accept   = w_div_req & (b != '0);
    assign w_div_zero_req = w_div_req & (b == '0);
    assign div_zero       = r_div_zero;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .i_rem     (r_acc_hi[WIDTH-1:0]),
        .i_quo     (r_acc_lo),
        .i_divisor (r_mcand),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );
`else
    logic w_unused_div_start;
    assign w_unused_div_start = div_start;
    assign w_div_accept       = 1'b0;
    assign div_zero           = 1'b0;
`endif

    assign w_last = (r_cnt == c_LAST_ITER);
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign hi     = r_hi;
    assign lo     = r_lo;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mult_start)        w_state_next = ST_MULT_RUN;
                else if (w_div_accept) w_state_next = ST_DIV_RUN;
            end
            ST_MULT_RUN: if (w_last) w_state_next = ST_DONE;
            ST_DIV_RUN:  if (w_last) w_state_next = ST_DIV_FIX;
            ST_DIV_FIX:  w_state_next = ST_DONE;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Radix-2 Booth step followed by an arithmetic right shift of {hi, lo, guard}.
    always_comb begin
        w_mcand_ext = {r_mcand[WIDTH-1], r_mcand};
        case ({r_acc_lo[0], r_guard})
            2'b01:   w_booth_sum = r_acc_hi + w_mcand_ext;
            2'b10:   w_booth_sum = r_acc_hi - w_mcand_ext;
            default: w_booth_sum = r_acc_hi;
        endcase
        w_booth_hi    = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        w_booth_lo    = {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};
        w_booth_guard = r_acc_lo[0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_guard  <= 1'b0;
            r_mcand  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULTDIV_DIV_EN
            r_div_zero <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
`endif
        end else begin
`ifdef MULTDIV_DIV_EN
            r_div_zero <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (mult_start) begin
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_guard  <= 1'b0;
                        r_mcand  <= a;
                    end
`ifdef MULTDIV_DIV_EN
                    else if (w_div_accept) begin
                        r_acc_hi <= '0;
                        r_acc_lo <= a[WIDTH-1] ? -a : a;
                        r_mcand  <= b[WIDTH-1] ? -b : b;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                    end else if (w_div_zero_req) begin
                        r_div_zero <= 1'b1;
                    end
`endif
                end
                ST_MULT_RUN: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_acc_hi <= w_booth_hi;
                    r_acc_lo <= w_booth_lo;
                    r_guard  <= w_booth_guard;
                    if (w_last) begin
                        r_hi <= w_booth_hi[WIDTH-1:0];
                        r_lo <= w_booth_lo;
                    end
                end
`ifdef MULTDIV_DIV_EN
                ST_DIV_RUN: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_acc_hi <= {1'b0, w_rem_next};
                    r_acc_lo <= w_quo_next;
                end
                ST_DIV_FIX: begin
                    r_lo <= (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
                    r_hi <= r_sign_a ? -r_acc_hi[WIDTH-1:0] : r_acc_hi[WIDTH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit; divide cases need MULTDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
    import multdiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          t0       = 0;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle following start edge N is numbered N+1, so latency = cyc + 1 - t0.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'(done), 64'd0);
            end else begin
                e_mon = sb.pop_front();
                check_eq({e_mon.tag, "_hi"}, 64'(hi), 64'(e_mon.hi));
                check_eq({e_mon.tag, "_lo"}, 64'(lo), 64'(e_mon.lo));
                check_eq({e_mon.tag, "_lat"}, 64'(cyc + 1 - t0), 64'(e_mon.lat));
                last_hi = e_mon.hi;
                last_lo = e_mon.lo;
            end
        end
    end

    task automatic start_op(input logic is_div, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av; b = bv; mult_start = !is_div; div_start = is_div;
        @(negedge clk);
        t0 = cyc;
        mult_start = 1'b0; div_start = 1'b0;
        a = $urandom; b = $urandom;
        check_eq("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_mult(input string tag, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sbv, p;
        exp_t   e;
        sa = $signed(av); sbv = $signed(bv);
        p  = sa * sbv;
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MD_MULT_LAT; e.tag = tag;
        sb.push_back(e);
        start_op(1'b0, av, bv);
        wait_idle();
    endtask

`ifdef MULTDIV_DIV_EN
    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv);
        int   ia, ib;
        exp_t e;
        ia = av; ib = bv;
        e.lo = 32'(ia / ib); e.hi = 32'(ia % ib); e.lat = MD_DIV_LAT; e.tag = tag;
        sb.push_back(e);
        start_op(1'b1, av, bv);
        wait_idle();
    endtask
`endif

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hi"},   64'(hi),       64'd0);
        check_eq({tag, "_lo"},   64'(lo),       64'd0);
        check_eq({tag, "_busy"}, 64'(busy),     64'd0);
        check_eq({tag, "_done"}, 64'(done),     64'd0);
        check_eq({tag, "_dz"},   64'(div_zero), 64'd0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra, rb;
        reset = 1'b0; mult_start = 1'b0; div_start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        run_mult("mul_7x-3", 32'd7, 32'hFFFF_FFFD);
        check_eq("mul_7x-3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_mult("mul_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check_eq("mul_max_const", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
        run_mult("mul_minxmin", 32'h8000_0000, 32'h8000_0000);
        run_mult("mul_minx1", 32'h8000_0000, 32'd1);
        run_mult("mul_minx-1", 32'h8000_0000, 32'hFFFF_FFFF);
        run_mult("mul_zero", 32'h1234_5678, 32'd0);
        for (int i = 0; i < 4; i++) run_mult("mul_rand", $urandom, $urandom);

`ifdef MULTDIV_DIV_EN
        run_div("div_-7/2", 32'hFFFF_FFF9, 32'd2);
        check_eq("div_-7/2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        e.hi = 32'd0; e.lo = 32'h8000_0000; e.lat = MD_DIV_LAT; e.tag = "div_min/-1";
        sb.push_back(e);
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        run_div("div_7/-2", 32'd7, 32'hFFFF_FFFE);
        run_div("div_-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        run_div("div_small/big", 32'd3, 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd5;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_div("div_rand", ra, rb);
        end
        run_div("div_prior", 32'd1000, 32'd7);
`endif

        // Divide by zero (or divide with divider compiled out): no result, Hi/Lo held.
        @(negedge clk);
        a = 32'd5; b = 32'd0; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
`ifdef MULTDIV_DIV_EN
        check_eq("dz_pulse", 64'(div_zero), 64'd1);
`else
        check_eq("dz_tied", 64'(div_zero), 64'd0);
`endif
        check_eq("dz_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("dz_pulse_end", 64'(div_zero), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("dz_hold_hi", 64'(hi), 64'(last_hi));
        check_eq("dz_hold_lo", 64'(lo), 64'(last_lo));

        // Both starts together: multiply wins; later strobes and operand changes ignored.
        e.hi = 32'd0; e.lo = 32'd24; e.lat = MD_MULT_LAT; e.tag = "both_starts";
        sb.push_back(e);
        @(negedge clk);
        a = 32'd6; b = 32'd4; mult_start = 1'b1; div_start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        mult_start = 1'b0; div_start = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'd9; b = 32'd0; div_start = 1'b1; mult_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0; mult_start = 1'b0;
        check_eq("both_no_dz", 64'(div_zero), 64'd0);
        wait_idle();
        repeat (40) @(negedge clk);

        // Reset in the middle of a multiply.
        e.hi = 32'd0; e.lo = 32'd0; e.lat = MD_MULT_LAT; e.tag = "aborted";
        sb.push_back(e);
        start_op(1'b0, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        check_reset_outputs("rst_mid");
        repeat (40) @(negedge clk);
        check_eq("rst_mid_idle", 64'(busy), 64'd0);

        // Reset overrides a coincident start.
        @(negedge clk);
        reset = 1'b0; mult_start = 1'b1; a = 32'd3; b = 32'd3;
        @(negedge clk);
        reset = 1'b1; mult_start = 1'b0;
        check_eq("rst_over_start", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);

        run_mult("after_reset", 32'hFFFF_FF00, 32'd300);
        run_mult("back_to_back", 32'd11, 32'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
